// File: rtl/multiplex.sv
// rtl/multiplex.sv - round-robin merge of INC strobe/ready streams onto one tagged output stream
// Registered single-entry output stage; the priority pointer advances only past a granted input.

module multiplex #(
  parameter int ARGW = 16,
  parameter int INC  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INC-1:0]          arg_stb,
  input  logic [INC*ARGW-1:0]     arg_dat,
  output logic [INC-1:0]          arg_rdy,
  output logic                    out_stb,
  output logic [ARGW-1:0]         out_dat,
  output logic [$clog2(INC)-1:0]  out_idx,
  input  logic                    out_rdy
);

  localparam int IDXW = $clog2(INC);

  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] gnt;
  logic            found;
  logic            load;
  logic            xfer;
  logic [ARGW-1:0] gdat;

  assign load = ~out_stb | out_rdy;
  assign xfer = found & load & ~rst;

  // Two passes give the circular scan ptr..INC-1 then 0..ptr-1 without modulo arithmetic.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int i = 0; i < INC; i++) begin
      if (!found && arg_stb[i] && (IDXW'(i) >= ptr)) begin
        found = 1'b1;
        gnt   = IDXW'(i);
      end
    end
    for (int i = 0; i < INC; i++) begin
      if (!found && arg_stb[i] && (IDXW'(i) < ptr)) begin
        found = 1'b1;
        gnt   = IDXW'(i);
      end
    end
  end

  always_comb begin
    gdat    = '0;
    arg_rdy = '0;
    for (int i = 0; i < INC; i++) begin
      if (gnt == IDXW'(i)) begin
        gdat       = arg_dat[ARGW*i +: ARGW];
        arg_rdy[i] = xfer;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_stb <= 1'b0;
      out_dat <= '0;
      out_idx <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      out_stb <= 1'b1;
      out_dat <= gdat;
      out_idx <= gnt;
      ptr     <= (gnt == IDXW'(INC-1)) ? '0 : gnt + 1'b1;
    end else if (out_rdy) begin
      out_stb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multiplex.sv
// tb/tb_multiplex.sv - directed self-checking bench for multiplex with INC=3 and INC=5 instances

module tb_multiplex;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [2:0]  arg_stb3 = '0;
  logic [47:0] arg_dat3 = '0;
  logic [2:0]  arg_rdy3;
  logic        out_stb3;
  logic [15:0] out_dat3;
  logic [1:0]  out_idx3;
  logic        out_rdy3 = 1'b0;

  logic [4:0]  arg_stb5 = '0;
  logic [79:0] arg_dat5 = '0;
  logic [4:0]  arg_rdy5;
  logic        out_stb5;
  logic [15:0] out_dat5;
  logic [2:0]  out_idx5;
  logic        out_rdy5 = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  int rot_seq[7]  = '{0, 1, 2, 0, 1, 2, 0};
  int alt_seq[6]  = '{1, 4, 1, 4, 1, 4};

  always #5 clk = ~clk;

  multiplex #(.ARGW(16), .INC(3)) u3 (
    .clk(clk), .rst(rst),
    .arg_stb(arg_stb3), .arg_dat(arg_dat3), .arg_rdy(arg_rdy3),
    .out_stb(out_stb3), .out_dat(out_dat3), .out_idx(out_idx3), .out_rdy(out_rdy3)
  );

  multiplex #(.ARGW(16), .INC(5)) u5 (
    .clk(clk), .rst(rst),
    .arg_stb(arg_stb5), .arg_dat(arg_dat5), .arg_rdy(arg_rdy5),
    .out_stb(out_stb5), .out_dat(out_dat5), .out_idx(out_idx5), .out_rdy(out_rdy5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arg_stb3 = '0;
    arg_stb5 = '0;
    out_rdy3 = 1'b0;
    out_rdy5 = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    arg_stb3 = 3'b001;
    arg_dat3[15:0] = 16'h7777;
    out_rdy3 = 1'b0;
    tick();
    n_cmp++;
    if (out_stb3 !== 1'b1) begin n_fail++; $display("FAIL pre_reset_stb got %0b want 1", out_stb3); end
    arg_stb3 = 3'b111;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_stb3 !== 1'b0) begin n_fail++; $display("FAIL async_reset_stb got %0b want 0", out_stb3); end
    n_cmp++;
    if (arg_rdy3 !== 3'b000) begin n_fail++; $display("FAIL async_reset_rdy got %b want 000", arg_rdy3); end
    n_cmp++;
    if (out_dat3 !== 16'h0000 || out_idx3 !== 2'd0) begin
      n_fail++; $display("FAIL async_reset_dat got %h/%0d want 0000/0", out_dat3, out_idx3);
    end
    arg_stb3 = 3'b000;
    tick();
    #2;
    rst = 1'b0;
    #1;
    arg_stb3 = 3'b010;
    arg_dat3[31:16] = 16'hBEEF;
    out_rdy3 = 1'b1;
    #1;
    n_cmp++;
    if (arg_rdy3 !== 3'b010) begin n_fail++; $display("FAIL single_rdy got %b want 010", arg_rdy3); end
    tick();
    arg_stb3 = 3'b000;
    n_cmp++;
    if (out_stb3 !== 1'b1 || out_dat3 !== 16'hBEEF || out_idx3 !== 2'd1) begin
      n_fail++; $display("FAIL single_out got stb=%0b dat=%h idx=%0d want 1/beef/1", out_stb3, out_dat3, out_idx3);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    arg_stb3 = 3'b111;
    arg_dat3 = {16'h0002, 16'h0001, 16'h0000};
    out_rdy3 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      logic [2:0] exp_rdy;
      exp_rdy = 3'b001 << rot_seq[k];
      #1;
      n_cmp++;
      if (arg_rdy3 !== exp_rdy) begin n_fail++; $display("FAIL rot_rdy[%0d] got %b want %b", k, arg_rdy3, exp_rdy); end
      tick();
      n_cmp++;
      if (out_stb3 !== 1'b1 || out_idx3 !== 2'(rot_seq[k]) || out_dat3 !== 16'(rot_seq[k])) begin
        n_fail++;
        $display("FAIL rot_out[%0d] got stb=%0b idx=%0d dat=%h want 1/%0d", k, out_stb3, out_idx3, out_dat3, rot_seq[k]);
      end
    end
  endtask

  task automatic test_stall();
    arg_stb3 = 3'b100;
    arg_dat3[47:32] = 16'h1234;
    out_rdy3 = 1'b1;
    tick();
    n_cmp++;
    if (out_stb3 !== 1'b1 || out_dat3 !== 16'h1234 || out_idx3 !== 2'd2) begin
      n_fail++; $display("FAIL stall_setup got stb=%0b dat=%h idx=%0d want 1/1234/2", out_stb3, out_dat3, out_idx3);
    end
    out_rdy3 = 1'b0;
    arg_stb3 = 3'b111;
    arg_dat3 = {16'h00A2, 16'h00A1, 16'h00A0};
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if (arg_rdy3 !== 3'b000) begin n_fail++; $display("FAIL stall_rdy[%0d] got %b want 000", k, arg_rdy3); end
      tick();
      n_cmp++;
      if (out_stb3 !== 1'b1 || out_dat3 !== 16'h1234 || out_idx3 !== 2'd2) begin
        n_fail++; $display("FAIL stall_hold[%0d] got stb=%0b dat=%h idx=%0d want 1/1234/2", k, out_stb3, out_dat3, out_idx3);
      end
    end
    out_rdy3 = 1'b1;
    #1;
    n_cmp++;
    if (arg_rdy3 !== 3'b001) begin n_fail++; $display("FAIL stall_release_rdy got %b want 001", arg_rdy3); end
    tick();
    n_cmp++;
    if (out_idx3 !== 2'd0 || out_dat3 !== 16'h00A0) begin
      n_fail++; $display("FAIL stall_release_out got idx=%0d dat=%h want 0/00a0", out_idx3, out_dat3);
    end
  endtask

  task automatic test_drain();
    arg_stb3 = 3'b000;
    out_rdy3 = 1'b1;
    #1;
    n_cmp++;
    if (arg_rdy3 !== 3'b000) begin n_fail++; $display("FAIL drain_rdy got %b want 000", arg_rdy3); end
    tick();
    n_cmp++;
    if (out_stb3 !== 1'b0) begin n_fail++; $display("FAIL drain_stb got %0b want 0", out_stb3); end
    tick();
    tick();
    arg_stb3 = 3'b111;
    #1;
    n_cmp++;
    if (arg_rdy3 !== 3'b010) begin n_fail++; $display("FAIL drain_ptr_kept got %b want 010", arg_rdy3); end
    arg_stb3 = 3'b100;
    arg_dat3[47:32] = 16'hC0DE;
    #1;
    n_cmp++;
    if (arg_rdy3 !== 3'b100) begin n_fail++; $display("FAIL drain_lone2_rdy got %b want 100", arg_rdy3); end
    tick();
    arg_stb3 = 3'b000;
    n_cmp++;
    if (out_stb3 !== 1'b1 || out_idx3 !== 2'd2 || out_dat3 !== 16'hC0DE) begin
      n_fail++; $display("FAIL drain_lone2_out got stb=%0b idx=%0d dat=%h want 1/2/c0de", out_stb3, out_idx3, out_dat3);
    end
  endtask

  task automatic test_nonpow2();
    do_reset();
    for (int i = 0; i < 5; i++) arg_dat5[16*i +: 16] = 16'h0050 + 16'(i);
    arg_stb5 = 5'b10010;
    out_rdy5 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [4:0] exp_rdy;
      exp_rdy = 5'b00001 << alt_seq[k];
      #1;
      n_cmp++;
      if (arg_rdy5 !== exp_rdy) begin n_fail++; $display("FAIL np2_rdy[%0d] got %b want %b", k, arg_rdy5, exp_rdy); end
      tick();
      n_cmp++;
      if (out_stb5 !== 1'b1 || out_idx5 !== 3'(alt_seq[k]) || out_dat5 !== 16'h0050 + 16'(alt_seq[k])) begin
        n_fail++;
        $display("FAIL np2_out[%0d] got stb=%0b idx=%0d dat=%h want 1/%0d", k, out_stb5, out_idx5, out_dat5, alt_seq[k]);
      end
    end
    arg_stb5 = 5'b00000;
    out_rdy5 = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    arg_stb3 = 3'b001;
    arg_dat3[15:0] = 16'h5555;
    out_rdy3 = 1'b1;
    tick();
    arg_stb3 = 3'b000;
    out_rdy3 = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (out_stb3 !== 1'b1 || out_dat3 !== 16'h5555) begin
      n_fail++; $display("FAIL rms_held got stb=%0b dat=%h want 1/5555", out_stb3, out_dat3);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_stb3 !== 1'b0) begin n_fail++; $display("FAIL rms_async_stb got %0b want 0", out_stb3); end
    out_rdy3 = 1'b1;
    arg_stb3 = 3'b111;
    arg_dat3 = {16'h00E2, 16'h00E1, 16'h00E0};
    tick();
    n_cmp++;
    if (out_stb3 !== 1'b0 || arg_rdy3 !== 3'b000) begin
      n_fail++; $display("FAIL rms_during_reset got stb=%0b rdy=%b want 0/000", out_stb3, arg_rdy3);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (arg_rdy3 !== 3'b001) begin n_fail++; $display("FAIL rms_first_rdy got %b want 001", arg_rdy3); end
    tick();
    n_cmp++;
    if (out_stb3 !== 1'b1 || out_idx3 !== 2'd0 || out_dat3 !== 16'h00E0) begin
      n_fail++; $display("FAIL rms_first_out got stb=%0b idx=%0d dat=%h want 1/0/00e0", out_stb3, out_idx3, out_dat3);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rotation();
    test_stall();
    test_drain();
    test_nonpow2();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
